// File: rtl/ece593_alu_pkg.sv
// Shared definitions for the parametrised ECE593 ALU: opcodes, FSM states
// and the helper that fits the ID constant into the result width.
package ece593_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_ADD      = 3'b001,
    OP_SUB      = 3'b010,
    OP_XOR      = 3'b011,
    OP_MUL      = 3'b100,
    OP_AND      = 3'b101,
    OP_DISP     = 3'b110,
    OP_DISP_ALT = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  localparam int ID_MAX_W = 128;

  // Zero-extends or truncates a 32-bit ID word to 'width' bits; the caller
  // casts the return value down to its own result width.
  function automatic logic [ID_MAX_W-1:0] pack_id(input logic [31:0] id,
                                                  input int width);
    logic [ID_MAX_W-1:0] packed_id;
    packed_id = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) packed_id[i] = id[i];
    end
    return packed_id;
  endfunction

endpackage

// File: rtl/ece593_alu_mul.sv
// Unsigned DATA_W x DATA_W multiplier. The product is formed when the op is
// issued and shifted through MUL_LAT-1 stages alongside a valid bit; the
// top's result register is the final stage, giving MUL_LAT stages in total.
module ece593_alu_mul
  import ece593_alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic [2*DATA_W-1:0]   product_o,
  output logic                  valid_o
);

  localparam int RES_W = 2 * DATA_W;
  localparam int DEPTH = MUL_LAT - 1;

  logic [RES_W-1:0] prod_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Valid pipeline: cleared by reset so an abandoned multiply never completes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this edge.
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= start_i;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Product pipeline: stage 0 captures the full product at issue.
  always_ff @(posedge clk) begin
    // NOTE: datapath stages carry no reset; they are only consumed when the
    // matching valid bit, which is reset, says so.
    if (start_i) prod_q[0] <= RES_W'(a_i) * RES_W'(b_i);
    for (int i = 1; i < DEPTH; i++) prod_q[i] <= prod_q[i-1];
  end

  assign product_o = prod_q[DEPTH-1];
  assign valid_o   = valid_q[DEPTH-1];

endmodule

// File: rtl/ece593_alu_param.sv
// Parametrised ALU with start/busy/end handshake. Single-cycle ops complete
// one edge after issue; MUL holds busy while the multiplier pipeline drains.
// Optional build macro: ECE593_ALU_FLAGS_EN adds zero_flag and carry_flag.
module ece593_alu_param
  import ece593_alu_pkg::*;
#(
  parameter int          DATA_W  = 16,
  parameter int          MUL_LAT = 3,
  parameter logic [31:0] ID_WORD = 32'h4E494B4F
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_op,
  input  logic [2:0]          op_sel,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  output logic                busy,
  output logic                end_op,
  output logic [2*DATA_W-1:0] result
`ifdef ECE593_ALU_FLAGS_EN
  ,
  output logic                zero_flag,
  output logic                carry_flag
`endif
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               end_q, end_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [RES_W-1:0]   alu_res;
  logic [RES_W-1:0]   a_ext, b_ext;
  logic [RES_W-1:0]   mul_product;
  logic               mul_valid;
  logic               issue;
  op_t                op;

`ifdef ECE593_ALU_FLAGS_EN
  logic               alu_carry;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
`endif

  assign op    = op_t'(op_sel);
  assign issue = start_op && (state_q == ST_IDLE);
  assign a_ext = RES_W'(A);
  assign b_ext = RES_W'(B);

  ece593_alu_mul #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (issue && (op == OP_MUL)),
    .a_i       (A),
    .b_i       (B),
    .product_o (mul_product),
    .valid_o   (mul_valid)
  );

  // Single-cycle datapath evaluated on the operands presented at issue.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    alu_res = '0;
`ifdef ECE593_ALU_FLAGS_EN
    alu_carry = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        alu_res = a_ext + b_ext;
`ifdef ECE593_ALU_FLAGS_EN
        alu_carry = alu_res[DATA_W];
`endif
      end
      OP_SUB: begin
        alu_res = a_ext - b_ext;
`ifdef ECE593_ALU_FLAGS_EN
        alu_carry = (A < B);
`endif
      end
      OP_XOR:              alu_res = a_ext ^ b_ext;
      OP_AND:              alu_res = a_ext & b_ext;
      OP_DISP, OP_DISP_ALT: alu_res = RES_W'(pack_id(ID_WORD, RES_W));
      default:             alu_res = '0;
    endcase
  end

  // Next-state, counter and completion logic for the handshake FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    end_d    = 1'b0;
    result_d = result_q;
`ifdef ECE593_ALU_FLAGS_EN
    zero_d   = zero_q;
    carry_d  = carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_op) begin
          if (op == OP_MUL) begin
            state_d = ST_MUL_WAIT;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else begin
            end_d    = 1'b1;
            result_d = alu_res;
`ifdef ECE593_ALU_FLAGS_EN
            carry_d  = alu_carry;
`endif
          end
        end
      end
      ST_MUL_WAIT: begin
        if ((cnt_q == CNT_W'(1)) && mul_valid) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          end_d    = 1'b1;
          result_d = mul_product;
`ifdef ECE593_ALU_FLAGS_EN
          carry_d  = 1'b0;
`endif
        end else if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ECE593_ALU_FLAGS_EN
    if (end_d) zero_d = (result_d == '0);
`endif
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      end_q    <= 1'b0;
      result_q <= '0;
`ifdef ECE593_ALU_FLAGS_EN
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      end_q    <= end_d;
      result_q <= result_d;
`ifdef ECE593_ALU_FLAGS_EN
      zero_q   <= zero_d;
      carry_q  <= carry_d;
`endif
    end
  end

  assign busy   = (state_q == ST_MUL_WAIT);
  assign end_op = end_q;
  assign result = result_q;
`ifdef ECE593_ALU_FLAGS_EN
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
`endif

endmodule

// File: tb/tb_ece593_alu_param.sv
// Directed self-checking bench for ece593_alu_param. Two instances share the
// stimulus: MUL_LAT=3 (main) and MUL_LAT=5 (only checked in the MUL latency
// step). Edges are counted with the issue edge as edge 1.
module tb_ece593_alu_param;
  import ece593_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_op;
  logic [2:0]  op_sel;
  logic [15:0] A, B;

  logic        busy, end_op;
  logic [31:0] result;
  logic        busy5, end_op5;
  logic [31:0] result5;
`ifdef ECE593_ALU_FLAGS_EN
  logic        zero_flag, carry_flag, zero_flag5, carry_flag5;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ece593_alu_param #(.DATA_W(16), .MUL_LAT(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .start_op(start_op), .op_sel(op_sel),
    .A(A), .B(B), .busy(busy), .end_op(end_op), .result(result)
`ifdef ECE593_ALU_FLAGS_EN
    , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
  );

  ece593_alu_param #(.DATA_W(16), .MUL_LAT(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .start_op(start_op), .op_sel(op_sel),
    .A(A), .B(B), .busy(busy5), .end_op(end_op5), .result(result5)
`ifdef ECE593_ALU_FLAGS_EN
    , .zero_flag(zero_flag5), .carry_flag(carry_flag5)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input op_t op,
                       input logic [15:0] a, input logic [15:0] b);
    start_op = s;
    op_sel   = op;
    A        = a;
    B        = b;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, OP_ADD, 16'd5, 16'd7);

    // Reset held three cycles with a pending ADD request.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_end_op", end_op, 1'b0);
      check("rst_busy",   busy,   1'b0);
      check("rst_result", result, 32'h0);
    end
`ifdef ECE593_ALU_FLAGS_EN
    check("rst_zero",  zero_flag,  1'b0);
    check("rst_carry", carry_flag, 1'b0);
`endif

    // First issue after release completes normally.
    reset_n = 1'b1;
    tick();
    check("post_rst_add_end", end_op, 1'b1);
    check("post_rst_add_res", result, 32'h0000000C);
    drive(1'b0, OP_NOP, 16'd0, 16'd0);
    tick();
    check("idle_end_low",   end_op, 1'b0);
    check("idle_res_held",  result, 32'h0000000C);

    // MUL 0xFFFF*0xFFFF: lat3 ends on edge 3, lat5 ends on edge 5.
    drive(1'b1, OP_MUL, 16'hFFFF, 16'hFFFF);
    tick();
    check("mul_e1_busy",   busy,   1'b1);
    check("mul_e1_end",    end_op, 1'b0);
    check("mul5_e1_busy",  busy5,  1'b1);
    drive(1'b0, OP_NOP, 16'd0, 16'd0);
    tick();
    check("mul_e2_busy",   busy,   1'b1);
    check("mul_e2_end",    end_op, 1'b0);
    check("mul_e2_res",    result, 32'h0000000C);
    tick();
    check("mul_e3_end",    end_op, 1'b1);
    check("mul_e3_busy",   busy,   1'b0);
    check("mul_e3_res",    result, 32'hFFFE0001);
    check("mul5_e3_busy",  busy5,  1'b1);
    check("mul5_e3_end",   end_op5, 1'b0);
`ifdef ECE593_ALU_FLAGS_EN
    check("mul_carry",     carry_flag, 1'b0);
    check("mul_zero",      zero_flag,  1'b0);
`endif
    tick();
    check("mul_e4_end",    end_op,  1'b0);
    check("mul5_e4_busy",  busy5,   1'b1);
    check("mul5_e4_end",   end_op5, 1'b0);
    tick();
    check("mul5_e5_end",   end_op5, 1'b1);
    check("mul5_e5_busy",  busy5,   1'b0);
    check("mul5_e5_res",   result5, 32'hFFFE0001);
    tick();
    check("mul5_e6_end",   end_op5, 1'b0);

    // Back-to-back single-cycle ops, one end_op per edge.
    drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001);
    tick();
    check("add_end", end_op, 1'b1);
    check("add_res", result, 32'h00010000);
`ifdef ECE593_ALU_FLAGS_EN
    check("add_carry", carry_flag, 1'b1);
`endif
    drive(1'b1, OP_SUB, 16'd3, 16'd5);
    tick();
    check("sub_end", end_op, 1'b1);
    check("sub_res", result, 32'hFFFFFFFE);
`ifdef ECE593_ALU_FLAGS_EN
    check("sub_borrow", carry_flag, 1'b1);
    check("sub_zero",   zero_flag,  1'b0);
`endif
    drive(1'b1, OP_XOR, 16'hA5A5, 16'h5A5A);
    tick();
    check("xor_end", end_op, 1'b1);
    check("xor_res", result, 32'h0000FFFF);
    drive(1'b1, OP_AND, 16'hF0F0, 16'h0FF0);
    tick();
    check("and_end", end_op, 1'b1);
    check("and_res", result, 32'h000000F0);
    drive(1'b1, OP_NOP, 16'h1234, 16'h5678);
    tick();
    check("nop_end", end_op, 1'b1);
    check("nop_res", result, 32'h0);
`ifdef ECE593_ALU_FLAGS_EN
    check("nop_zero", zero_flag, 1'b1);
`endif
    drive(1'b1, OP_DISP, 16'h0, 16'h0);
    tick();
    check("disp_end", end_op, 1'b1);
    check("disp_res", result, 32'h4E494B4F);
    drive(1'b1, OP_DISP_ALT, 16'h1, 16'h1);
    tick();
    check("disp_alt_end", end_op, 1'b1);
    check("disp_alt_res", result, 32'h4E494B4F);

    // Busy blocking: ADD during the MUL is dropped; ADD in end_op cycle runs.
    drive(1'b1, OP_MUL, 16'd2, 16'd3);
    tick();
    check("blk_e1_busy", busy,   1'b1);
    check("blk_e1_end",  end_op, 1'b0);
    drive(1'b1, OP_ADD, 16'd1, 16'd1);
    tick();
    check("blk_e2_busy", busy,   1'b1);
    check("blk_e2_end",  end_op, 1'b0);
    check("blk_e2_res",  result, 32'h4E494B4F);
    drive(1'b0, OP_NOP, 16'd0, 16'd0);
    tick();
    check("blk_mul_end", end_op, 1'b1);
    check("blk_mul_res", result, 32'h00000006);
    check("blk_mul_busy", busy,  1'b0);
    drive(1'b1, OP_ADD, 16'd1, 16'd1);
    tick();
    check("blk_add_end", end_op, 1'b1);
    check("blk_add_res", result, 32'h00000002);
    drive(1'b0, OP_NOP, 16'd0, 16'd0);
    tick();
    check("blk_idle_end", end_op, 1'b0);
    check("blk_idle_res", result, 32'h00000002);

    // SUB 5-5 gives zero with no borrow.
    drive(1'b1, OP_SUB, 16'd5, 16'd5);
    tick();
    check("sub0_res", result, 32'h0);
`ifdef ECE593_ALU_FLAGS_EN
    check("sub0_zero",  zero_flag,  1'b1);
    check("sub0_carry", carry_flag, 1'b0);
`endif

    // Reset on the second cycle of a MUL abandons it.
    drive(1'b1, OP_MUL, 16'd9, 16'd9);
    tick();
    check("mid_e1_busy", busy, 1'b1);
    drive(1'b0, OP_NOP, 16'd0, 16'd0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_busy", busy,   1'b0);
    check("mid_rst_end",  end_op, 1'b0);
    check("mid_rst_res",  result, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_after_end",  end_op, 1'b0);
      check("mid_after_busy", busy,   1'b0);
      check("mid_after_res",  result, 32'h0);
    end

    // Recovery after the abandoned multiply.
    drive(1'b1, OP_ADD, 16'd1, 16'd2);
    tick();
    check("recover_end", end_op, 1'b1);
    check("recover_res", result, 32'h00000003);
    drive(1'b0, OP_NOP, 16'd0, 16'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
